oddr_feed_serializer: RTL and testbench
=======================================

ODDR_FEED_SERIALIZER -- requirements
Module: oddr_feed_serializer

Interface
REQ-001 Parameter DATA_W, default 16, width of the parallel input word; SHALL be even and >= 4.
REQ-002 Parameter IDLE_LEVEL, default 1'b0, level driven on both ODDR data lanes when not transmitting.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  transmit enable.
REQ-006 mode  input  1  source select: 0 = stream input, 1 = internal PRBS7.
REQ-007 s_data  input  DATA_W  parallel word to serialize.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  block can accept s_data this cycle.
REQ-010 d_rise  output  1  bit for the ODDR rising-edge input (D1).
REQ-011 d_fall  output  1  bit for the ODDR falling-edge input (D2).
REQ-012 out_active  output  1  high while d_rise/d_fall carry payload.
REQ-013 underrun  output  1  one-cycle pulse when stream data ran dry while enabled.
REQ-014 word_count  output  16  count of completed stream words.

Function
REQ-015 FSM states IDLE, STREAM, PRBS; all outputs SHALL be registered.
REQ-016 Transfer occurs on s_valid && s_ready; s_ready = holding register empty, independent of s_valid.
REQ-017 Storage: one shift register plus one holding register (2 words total); an accepted word goes to the holding register and moves to the shift register when it is empty or on the last pair of the current word.
REQ-018 Order MSB first: in pair k (k = 0..DATA_W/2-1), d_rise = bit DATA_W-1-2k, d_fall = bit DATA_W-2-2k.
REQ-019 Latency: in IDLE, a word accepted in cycle N with enable=1 and mode=0 SHALL produce pair 0 on the outputs in cycle N+1.
REQ-020 IDLE -> STREAM when enable=1, mode=0 and a word is available; IDLE -> PRBS when enable=1 and mode=1.
REQ-021 mode SHALL be sampled only in IDLE; changes during STREAM/PRBS are ignored until IDLE is re-entered.
REQ-022 Back-to-back words SHALL be gapless: if the holding register is full at the last pair, pair 0 of the next word follows in the next cycle.
REQ-023 End of word with enable=1 and holding register empty: underrun pulses for 1 cycle, outputs go to IDLE_LEVEL, FSM -> IDLE.
REQ-024 enable deasserted in STREAM: the current word completes, then FSM -> IDLE with no underrun pulse; a buffered word is kept.
REQ-025 PRBS: LFSR x^7+x^6+1, seed 7'h7F, advanced twice per cycle; d_rise takes the first new bit, d_fall the second; sequence period 127 bits.
REQ-026 PRBS -> IDLE in the cycle after enable=0; the LFSR re-seeds on every IDLE -> PRBS entry.
REQ-027 In PRBS state, s_ready SHALL be 0.
REQ-028 out_active = 1 exactly in the cycles in which a payload pair is driven; otherwise d_rise = d_fall = IDLE_LEVEL.
REQ-029 word_count SHALL increment on the last pair of each stream word and wrap 16'hFFFF -> 0.

Reset
REQ-030 With rst=1 at a clock edge: FSM = IDLE, both registers empty, s_ready=1 (takes effect the cycle after rst drops), d_rise=d_fall=IDLE_LEVEL, out_active=0, underrun=0, word_count=0, LFSR=7'h7F.
REQ-031 Reset mid-word SHALL discard all buffered data with no underrun pulse.

Structure
REQ-032 Package oddr_feed_pkg SHALL hold the FSM state enum, PRBS7 seed and tap constants.
REQ-033 The LFSR SHALL be a sub-module prbs7_gen (2-bit-per-cycle step, synchronous load of the seed); all other logic stays in oddr_feed_serializer.

Verification
REQ-034 Single word: enable=1, mode=0, s_data=16'hA5C3 -> pairs (1,0),(1,0),(0,1),(0,1),(1,1),(0,0),(0,0),(1,1) in 8 consecutive cycles starting at N+1; out_active high for those 8 cycles, then underrun pulses and word_count=1.
REQ-035 Streaming: 4 words with s_valid held high -> 32 consecutive active cycles with no gap, word_count=4, a single underrun pulse at the end.
REQ-036 Graceful stop: enable dropped at pair 3 -> pairs 4..7 still driven, then IDLE_LEVEL, no underrun pulse.
REQ-037 PRBS: mode=1, enable=1 for 200 cycles -> output bit stream matches a reference PRBS7 model (seed 7'h7F) and repeats every 127 bits; s_ready=0 throughout.
REQ-038 Reset mid-word: rst=1 at pair 2 -> the next cycle shows outputs at IDLE_LEVEL, word_count=0, s_ready=1, no underrun pulse.
REQ-039 Wrap: word_count preloaded via force to 16'hFFFF, one word sent -> word_count=0.

Source files
------------

// File: rtl/oddr_feed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oddr_feed_pkg
// Description : Shared definitions for the ODDR feed serializer.
//               Holds the FSM state encoding, the PRBS7 seed and tap
//               positions, and the single-step PRBS7 LFSR function.
// Revision    : 1.0 - initial release
// ============================================================================
package oddr_feed_pkg;

  // Serializer operating modes
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PRBS   = 2'd2
  } state_e;

  // PRBS7 polynomial x^7 + x^6 + 1. The register shifts toward bit 6, so
  // bit 6 holds the oldest bit (x^7 term) and bit 5 the x^6 term.
  localparam logic [6:0] c_prbs7_seed  = 7'h7F;
  localparam int         c_prbs7_tap_a = 6;
  localparam int         c_prbs7_tap_b = 5;

  // One LFSR step; the newly generated bit lands in bit 0.
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[c_prbs7_tap_a] ^ s[c_prbs7_tap_b]};
  endfunction

endpackage : oddr_feed_pkg
`default_nettype wire

// File: rtl/prbs7_gen.sv
`default_nettype none
// ============================================================================
// Module      : prbs7_gen
// Description : PRBS7 (x^7 + x^6 + 1) generator producing two bits per cycle.
// Ports       : clk      - system clock (rising edge)
//               rst      - synchronous active-high reset, loads the seed
//               seed_i   - restart the sequence from the seed this cycle
//               step_i   - advance the sequence by two bits this cycle
//               bits_o   - next two sequence bits; [1] first, [0] second
// Revision    : 1.0 - initial release
// ============================================================================
module prbs7_gen
  import oddr_feed_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_i,
  input  logic       step_i,
  output logic [1:0] bits_o
);

  logic [6:0] lfsr_q;
  logic [6:0] w_base;
  logic [6:0] w_mid;
  logic [6:0] w_end;

  // When seed_i is set the two output bits come straight from the seed, so
  // the first pair is available in the same cycle the restart is requested.
  assign w_base = seed_i ? c_prbs7_seed : lfsr_q;
  assign w_mid  = prbs7_step(w_base);
  assign w_end  = prbs7_step(w_mid);
  assign bits_o = {w_mid[0], w_end[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= c_prbs7_seed;
    end else if (seed_i || step_i) begin
      lfsr_q <= w_end;
    end
  end

endmodule : prbs7_gen
`default_nettype wire

// File: rtl/oddr_feed_serializer.sv
`default_nettype none
// ============================================================================
// Module      : oddr_feed_serializer
// Description : Feeds an ODDR primitive two bits per clock, either from a
//               parallel word stream (MSB first) or from an internal PRBS7.
//               One shift register plus one holding register give gapless
//               back-to-back words.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               enable, mode    - transmit enable, source (0 stream, 1 PRBS7)
//               s_data/s_valid/s_ready - word input handshake
//               d_rise, d_fall  - ODDR D1/D2 data
//               out_active      - payload pair on d_rise/d_fall
//               underrun        - 1-cycle pulse, stream ran dry while enabled
//               word_count      - completed stream words (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module oddr_feed_serializer
  import oddr_feed_pkg::*;
#(
  parameter int   DATA_W     = 16,   // even, >= 4
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              d_rise,
  output logic              d_fall,
  output logic              out_active,
  output logic              underrun,
  output logic [15:0]       word_count
);

  localparam int c_pairs  = DATA_W / 2;
  localparam int c_pair_w = (c_pairs > 1) ? $clog2(c_pairs) : 1;
  localparam logic [c_pair_w-1:0] c_last_pair = c_pair_w'(c_pairs - 1);

  state_e              state_q,     state_d;
  logic [DATA_W-1:0]   shift_q,     shift_d;
  logic [c_pair_w-1:0] pair_q,      pair_d;
  logic [DATA_W-1:0]   hold_q,      hold_d;
  logic                hold_full_q, hold_full_d;
  logic                s_ready_q,   s_ready_d;
  logic                d_rise_q,    d_rise_d;
  logic                d_fall_q,    d_fall_d;
  logic                active_q,    active_d;
  logic                underrun_q,  underrun_d;
  logic [15:0]         count_q,     count_d;

  logic                w_accept;
  logic                w_avail;
  logic [DATA_W-1:0]   w_next_word;
  logic                w_start;
  logic                w_prbs_seed;
  logic                w_prbs_step;
  logic [1:0]          w_prbs_bits;

  prbs7_gen u_prbs7_gen (
    .clk    (clk),
    .rst    (rst),
    .seed_i (w_prbs_seed),
    .step_i (w_prbs_step),
    .bits_o (w_prbs_bits)
  );

  // A word is available if the holding register has one, or one is being
  // accepted right now (it passes through the holding register in the same
  // edge). s_ready implies the holding register is empty, so both never
  // compete.
  assign w_accept    = s_valid && s_ready_q;
  assign w_avail     = hold_full_q || w_accept;
  assign w_next_word = hold_full_q ? hold_q : s_data;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    pair_d      = pair_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    d_rise_d    = IDLE_LEVEL;
    d_fall_d    = IDLE_LEVEL;
    active_d    = 1'b0;
    underrun_d  = 1'b0;
    count_d     = count_q;
    w_start     = 1'b0;
    w_prbs_seed = 1'b0;
    w_prbs_step = 1'b0;

    if (w_accept) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // mode is only looked at here; it is frozen for the whole run.
        if (enable && mode) begin
          state_d     = ST_PRBS;
          w_prbs_seed = 1'b1;
          d_rise_d    = w_prbs_bits[1];
          d_fall_d    = w_prbs_bits[0];
          active_d    = 1'b1;
        end else if (enable && w_avail) begin
          w_start = 1'b1;
        end
      end

      ST_STREAM: begin
        if (pair_q != c_last_pair) begin
          pair_d   = pair_q + c_pair_w'(1);
          d_rise_d = shift_q[DATA_W-1];
          d_fall_d = shift_q[DATA_W-2];
          shift_d  = {shift_q[DATA_W-3:0], 2'b00};
          active_d = 1'b1;
        end else begin
          count_d = count_q + 16'd1;
          if (enable && w_avail) begin
            w_start = 1'b1;
          end else begin
            // Running dry is only an error while still enabled; a deliberate
            // stop keeps any buffered word for later.
            state_d    = ST_IDLE;
            underrun_d = enable;
          end
        end
      end

      ST_PRBS: begin
        if (enable) begin
          w_prbs_step = 1'b1;
          d_rise_d    = w_prbs_bits[1];
          d_fall_d    = w_prbs_bits[0];
          active_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Load a new word: pair 0 goes straight to the outputs, the rest of the
    // word waits in the shift register already aligned to the MSB.
    if (w_start) begin
      state_d     = ST_STREAM;
      d_rise_d    = w_next_word[DATA_W-1];
      d_fall_d    = w_next_word[DATA_W-2];
      shift_d     = {w_next_word[DATA_W-3:0], 2'b00};
      pair_d      = '0;
      hold_full_d = 1'b0;
      active_d    = 1'b1;
    end
  end

  assign s_ready_d = (state_d != ST_PRBS) && !hold_full_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      pair_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      s_ready_q   <= 1'b1;
      d_rise_q    <= IDLE_LEVEL;
      d_fall_q    <= IDLE_LEVEL;
      active_q    <= 1'b0;
      underrun_q  <= 1'b0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pair_q      <= pair_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      s_ready_q   <= s_ready_d;
      d_rise_q    <= d_rise_d;
      d_fall_q    <= d_fall_d;
      active_q    <= active_d;
      underrun_q  <= underrun_d;
      count_q     <= count_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign d_rise     = d_rise_q;
  assign d_fall     = d_fall_q;
  assign out_active = active_q;
  assign underrun   = underrun_q;
  assign word_count = count_q;

endmodule : oddr_feed_serializer
`default_nettype wire

// File: tb/tb_oddr_feed_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_oddr_feed_serializer
// Description : Self-checking bench for oddr_feed_serializer. A behavioural
//               model (word queue, pair index, PRBS7 bit history) predicts
//               every output each cycle; directed scenarios add checks
//               against hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oddr_feed_serializer;

  localparam int   DW = 16;
  localparam logic IL = 1'b0;

  logic          clk = 1'b0;
  logic          rst, enable, mode, s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready, d_rise, d_fall, out_active, underrun;
  logic [15:0]   word_count;

  int n_checks = 0;
  int n_errors = 0;

  oddr_feed_serializer #(.DATA_W(DW), .IDLE_LEVEL(IL)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .d_rise     (d_rise),
    .d_fall     (d_fall),
    .out_active (out_active),
    .underrun   (underrun),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [DW-1:0] m_hold[$];
  bit            m_busy, m_prbs, m_ready;
  logic [DW-1:0] m_word;
  int            m_k;
  logic [15:0]   m_count;
  bit            e_rise, e_fall, e_act, e_und;
  bit            p_hist[$];   // last 7 PRBS bits, oldest first

  task automatic prbs_bit(output bit b);
    b = p_hist[0] ^ p_hist[1];   // x[n] = x[n-7] ^ x[n-6]
    void'(p_hist.pop_front());
    p_hist.push_back(b);
  endtask

  task automatic reseed();
    p_hist.delete();
    repeat (7) p_hist.push_back(1'b1);
  endtask

  task automatic emit_pair();
    e_act  = 1'b1;
    e_rise = m_word[DW-1-2*m_k];
    e_fall = m_word[DW-2-2*m_k];
  endtask

  task automatic emit_prbs();
    bit a, b;
    prbs_bit(a);
    prbs_bit(b);
    e_act  = 1'b1;
    e_rise = a;
    e_fall = b;
  endtask

  task automatic model_step();
    bit acc, ending;
    e_rise = IL; e_fall = IL; e_act = 1'b0; e_und = 1'b0;
    if (rst) begin
      m_hold.delete();
      m_busy = 0; m_prbs = 0; m_k = 0; m_count = 16'd0; m_ready = 1;
      reseed();
      return;
    end
    acc = s_valid && m_ready;
    if (acc) m_hold.push_back(s_data);
    if (m_prbs) begin
      if (enable) emit_prbs();
      else m_prbs = 0;
    end else if (m_busy && m_k < DW/2-1) begin
      m_k++;
      emit_pair();
    end else begin
      ending = m_busy;
      if (ending) m_count = m_count + 16'd1;
      m_busy = 0;
      if (!ending && enable && mode) begin
        m_prbs = 1;
        reseed();
        emit_prbs();
      end else if (enable && m_hold.size() > 0) begin
        m_word = m_hold.pop_front();
        m_k    = 0;
        m_busy = 1;
        emit_pair();
      end else if (ending && enable) begin
        e_und = 1'b1;
      end
    end
    m_ready = !m_prbs && (m_hold.size() == 0);
  endtask

  // One clock: model advances at the edge, DUT is compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pins", {27'd0, d_rise, d_fall, out_active, underrun, s_ready},
                {27'd0, e_rise, e_fall, e_act, e_und, m_ready});
    chk("count", {16'd0, word_count}, {16'd0, m_count});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- tests
  logic [15:0] exp_pairs;
  logic [15:0] cnt0;
  logic        will_acc;
  int          accepted, act_run, max_run, und_n, act_n, ready_hi, per_err;
  bit          obs[$];
  logic [7:0]  head;

  initial begin
    rst = 1; enable = 0; mode = 0; s_valid = 0; s_data = '0;
    tick(); tick();
    rst = 0;
    chk("rst_ready",  {31'd0, s_ready}, 32'd1);
    chk("rst_active", {31'd0, out_active}, 32'd0);
    chk("rst_pins",   {30'd0, d_rise, d_fall}, {30'd0, IL, IL});
    chk("rst_count",  {16'd0, word_count}, 32'd0);

    // Single word A5C3: pairs start the cycle after acceptance.
    exp_pairs = 16'b10_10_01_01_11_00_00_11;
    enable = 1; mode = 0; s_valid = 1; s_data = 16'hA5C3;
    tick();
    s_valid = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk("a5c3_pair", {29'd0, d_rise, d_fall, out_active},
                       {29'd0, exp_pairs[15-2*k], exp_pairs[14-2*k], 1'b1});
    end
    tick();
    chk("a5c3_end",   {30'd0, out_active, underrun}, 32'b01);
    chk("a5c3_count", {16'd0, word_count}, 32'd1);
    tick();
    chk("a5c3_pulse", {31'd0, underrun}, 32'd0);

    // Four streamed words with s_valid held high: gapless 32-cycle burst.
    cnt0 = word_count; accepted = 0; act_run = 0; max_run = 0; und_n = 0;
    s_valid = 1; s_data = DW'($urandom);
    for (int c = 0; c < 60; c++) begin
      will_acc = s_valid && s_ready;
      tick();
      if (will_acc) begin
        accepted++;
        s_data = DW'($urandom);
        if (accepted == 4) s_valid = 0;
      end
      if (out_active) act_run++; else act_run = 0;
      if (act_run > max_run) max_run = act_run;
      if (underrun) und_n++;
    end
    chk("burst_accepted", accepted, 4);
    chk("burst_run", max_run, 32);
    chk("burst_underrun", und_n, 1);
    chk("burst_count", {16'd0, word_count - cnt0}, 32'd4);

    // Graceful stop: enable drops while pair 3 is on the wire.
    s_valid = 1; s_data = DW'($urandom);
    tick();
    s_valid = 0;
    tick(); tick(); tick();
    enable = 0; act_n = 0; und_n = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_active) act_n++;
      if (underrun) und_n++;
    end
    chk("stop_tail", act_n, 4);
    chk("stop_underrun", und_n, 0);
    chk("stop_idle", {30'd0, d_rise, d_fall}, {30'd0, IL, IL});

    // PRBS7 for 200 cycles.
    obs.delete(); ready_hi = 0; per_err = 0;
    enable = 1; mode = 1;
    for (int c = 0; c < 200; c++) begin
      tick();
      obs.push_back(d_rise);
      obs.push_back(d_fall);
      if (s_ready) ready_hi++;
      if (c == 20) mode = 0;   // ignored until IDLE
    end
    for (int i = 0; i < 8; i++) head[7-i] = obs[i];
    chk("prbs_head", {24'd0, head}, 32'b0000_0010);
    for (int n = 127; n < obs.size(); n++)
      if (obs[n] != obs[n-127]) per_err++;
    chk("prbs_period", per_err, 0);
    chk("prbs_ready", ready_hi, 0);
    enable = 0;
    tick();
    chk("prbs_stop", {31'd0, out_active}, 32'd0);

    // Reset in the middle of a word with a second word buffered.
    mode = 0; enable = 1; s_valid = 1; s_data = DW'($urandom);
    tick();
    s_data = DW'($urandom);
    tick();
    s_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_pins",  {29'd0, d_rise, d_fall, out_active}, {29'd0, IL, IL, 1'b0});
    chk("mid_rst_count", {16'd0, word_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, s_ready}, 32'd1);
    chk("mid_rst_und",   {31'd0, underrun}, 32'd0);
    act_n = 0;
    repeat (4) begin
      tick();
      if (out_active || underrun) act_n++;
    end
    chk("mid_rst_discard", act_n, 0);

    // word_count wrap.
    force dut.count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    tick();
    release dut.count_q;
    tick();
    chk("wrap_pre", {16'd0, word_count}, 32'h0000_FFFF);
    s_valid = 1; s_data = DW'($urandom);
    tick();
    s_valid = 0;
    repeat (8) tick();
    chk("wrap", {16'd0, word_count}, 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      enable  = ($urandom % 8) != 0;
      mode    = ($urandom % 5) == 0;
      s_valid = ($urandom % 4) != 0;
      s_data  = DW'($urandom);
      rst     = ($urandom % 250) == 0;
      tick();
    end
    rst = 0; enable = 0; s_valid = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_oddr_feed_serializer
`default_nettype wire
